// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 divider: FSM state encoding and constant helpers.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package div_pkg;

    // Widest operand the constant helpers below can describe.
    localparam int DIV_MAX_W = 128;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_CALC_ENC = 2'd1;
    localparam logic [1:0] ST_FIX_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_CALC = ST_CALC_ENC,
        ST_FIX  = ST_FIX_ENC
    } div_state_e;

    // Most negative two's-complement value of a 'width'-bit word, zero-extended
    // to DIV_MAX_W bits; callers slice off the low 'width' bits.
    function automatic logic [DIV_MAX_W-1:0] signed_min(input int unsigned width);
        return DIV_MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/radix2_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, subtract divisor when it fits.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning FSM.
// Ports: rem_i/quo_i current partial remainder and quotient, dvsr_i divisor magnitude,
//        rem_o/quo_o the pair after one step.
module radix2_div_step
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder needs XLEN+1 bits: with a divisor whose MSB is set
    // the partial remainder can reach 2*divisor-1 before the compare.
    logic [XLEN:0] shifted;
    logic          fits;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign fits    = (shifted >= {1'b0, dvsr_i});
    // After a successful subtract the result is below the divisor, so the
    // top bit of 'shifted' is always discarded safely.
    assign rem_o   = fits ? (shifted[XLEN-1:0] - dvsr_i) : shifted[XLEN-1:0];
    assign quo_o   = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/radix2_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with flush abort.
// Latency: XLEN+2 cycles from accepted start to done; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: start is ignored while busy; no queuing, flush drops the in-flight op without done.
// Ports: clk/rst (async active-high), start/signed_op/dividend/divisor request, flush abort,
//        quotient/remainder/dbz/ovf results held until the next completion, busy, done pulse.
module radix2_divider
    import div_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            dbz,
    output logic            ovf,
    output logic            busy,
    output logic            done
);

    localparam logic [DIV_MAX_W-1:0] SMIN_FULL = signed_min(XLEN);
    localparam logic [XLEN-1:0]      SMIN      = SMIN_FULL[XLEN-1:0];

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            dvd_neg, dvs_neg, is_dbz, is_ovf;
    logic [XLEN-1:0] dvd_abs, dvs_abs;
    logic [XLEN-1:0] step_rem, step_quo;

    radix2_div_step #(.XLEN(XLEN)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Fast-path detection and operand magnitudes from the live request.
    // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(XLEN-1).
    assign dvd_neg = signed_op & dividend[XLEN-1];
    assign dvs_neg = signed_op & divisor[XLEN-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor  : divisor;
    assign is_dbz  = (divisor == '0);
    assign is_ovf  = signed_op && (dividend == SMIN) && (divisor == '1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // flush in the same cycle drops the request
                if (start && !flush) begin
                    if (is_dbz) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        done_d      = 1'b1;
                    end else if (is_ovf) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        rem_d     = '0;
                        quo_d     = dvd_abs;
                        dvsr_d    = dvs_abs;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                        cnt_d     = '0;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: directed cases plus randomized ops against a behavioural model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_radix2_divider;

    localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst, start, sop, flush;
    logic [63:0] dvd, dvs, q, r;
    logic        dbz, ovf, busy, done;

    logic        rst32, start32, sop32, flush32;
    logic [31:0] dvd32, dvs32, q32, r32;
    logic        dbz32, ovf32, busy32, done32;

    int n_checks = 0;
    int n_err    = 0;

    radix2_divider #(.XLEN(64)) u_dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(sop),
        .dividend(dvd), .divisor(dvs), .flush(flush),
        .quotient(q), .remainder(r), .dbz(dbz), .ovf(ovf),
        .busy(busy), .done(done)
    );

    radix2_divider #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst32), .start(start32), .signed_op(sop32),
        .dividend(dvd32), .divisor(dvs32), .flush(flush32),
        .quotient(q32), .remainder(r32), .dbz(dbz32), .ovf(ovf32),
        .busy(busy32), .done(done32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    // Architectural result of one divide op, straight from the ISA rules.
    task automatic ref_div(input logic s, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] rq, output logic [63:0] rr,
                           output logic rdz, output logic rov);
        rdz = 1'b0;
        rov = 1'b0;
        if (b == 64'd0) begin
            rq = ONES64; rr = a; rdz = 1'b1;
        end else if (s && a == MIN64 && b == ONES64) begin
            rq = a; rr = 64'd0; rov = 1'b1;
        end else if (s) begin
            rq = $signed(a) / $signed(b);
            rr = $signed(a) % $signed(b);
        end else begin
            rq = a / b;
            rr = a % b;
        end
    endtask

    // Cycle-level expectation: an op completes a fixed number of cycles after
    // acceptance unless flushed or reset; results appear with done and persist.
    logic [63:0] m_q, m_r, p_q, p_r;
    logic        m_dbz, m_ovf, p_dbz, p_ovf, m_done;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_q = 64'd0; m_r = 64'd0; m_dbz = 1'b0; m_ovf = 1'b0;
            m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
                    end
                end
            end else if (start && !flush) begin
                ref_div(sop, dvd, dvs, p_q, p_r, p_dbz, p_ovf);
                if (p_dbz || p_ovf) begin
                    m_done = 1'b1;
                    m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
                end else begin
                    m_left = 65;
                end
            end
        end
        #2;
        chk("cyc_busy", 64'(busy), 64'(m_left != 0));
        chk("cyc_done", 64'(done), 64'(m_done));
        chk("cyc_quotient", q, m_q);
        chk("cyc_remainder", r, m_r);
        chk("cyc_dbz", 64'(dbz), 64'(m_dbz));
        chk("cyc_ovf", 64'(ovf), 64'(m_ovf));
    end

    // Called at the negedge right after the start cycle.
    task automatic issue(input logic s, input logic [63:0] a, input logic [63:0] b);
        start = 1'b1; sop = s; dvd = a; dvs = b;
        @(negedge clk);
        start = 1'b0;
        sop   = 1'($urandom_range(0, 1));
        dvd   = {$urandom, $urandom};
        dvs   = {$urandom, $urandom};
    endtask

    // Returns the cycle index (relative to c0) in which done is seen.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_done: no done within 200 cycles, required one");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [63:0] a, b;
        logic        s;
        int          act;

        rst = 1'b1; start = 1'b0; sop = 1'b0; flush = 1'b0; dvd = '0; dvs = '0;
        rst32 = 1'b1; start32 = 1'b0; sop32 = 1'b0; flush32 = 1'b0; dvd32 = '0; dvs32 = '0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", q, 64'd0);
        chk("rst_remainder", r, 64'd0);
        chk("rst_dbz", 64'(dbz), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0; rst32 = 1'b0;
        @(negedge clk);

        // 100/7 unsigned
        issue(1'b0, 64'd100, 64'd7);
        chk("u100_7_busy_c1", 64'(busy), 64'd1);
        wait_done(1, cyc);
        chk("u100_7_latency", 64'(cyc), 64'd66);
        chk("u100_7_q", q, 64'd14);
        chk("u100_7_r", r, 64'd2);

        // -7/2 signed, started in the done cycle
        issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_done(1, cyc);
        chk("s_m7_2_latency", 64'(cyc), 64'd66);
        chk("s_m7_2_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("s_m7_2_r", r, ONES64);

        // unsigned divisor with MSB set
        issue(1'b0, ONES64, MIN64);
        wait_done(1, cyc);
        chk("u_msb_q", q, 64'd1);
        chk("u_msb_r", r, 64'h7FFF_FFFF_FFFF_FFFF);

        // divide by zero fast path
        issue(1'b0, 64'h1234, 64'd0);
        wait_done(1, cyc);
        chk("dbz_latency", 64'(cyc), 64'd1);
        chk("dbz_q", q, ONES64);
        chk("dbz_r", r, 64'h1234);
        chk("dbz_flag", 64'(dbz), 64'd1);

        // signed overflow fast path, then same operands unsigned
        issue(1'b1, MIN64, ONES64);
        wait_done(1, cyc);
        chk("ovf_latency", 64'(cyc), 64'd1);
        chk("ovf_q", q, MIN64);
        chk("ovf_r", r, 64'd0);
        chk("ovf_flag", 64'(ovf), 64'd1);
        issue(1'b0, MIN64, ONES64);
        wait_done(1, cyc);
        chk("u_min_latency", 64'(cyc), 64'd66);
        chk("u_min_q", q, 64'd0);
        chk("u_min_r", r, MIN64);
        chk("u_min_ovf", 64'(ovf), 64'd0);
        @(negedge clk);

        // flush in c10 of 1000/3
        issue(1'b0, 64'd1000, 64'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_c11", 64'(busy), 64'd0);
        chk("flush_q_kept", q, 64'd0);
        chk("flush_r_kept", r, MIN64);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("flush_no_done", 64'(seen), 64'd0);

        // flush and start together in IDLE: start dropped
        start = 1'b1; flush = 1'b1; sop = 1'b0; dvd = 64'd5; dvs = 64'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        // 9/3 with a start pulse while busy that must be ignored
        issue(1'b0, 64'd9, 64'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; dvd = 64'd50; dvs = 64'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(7, cyc);
        chk("u9_3_latency", 64'(cyc), 64'd66);
        chk("u9_3_q", q, 64'd3);
        chk("u9_3_r", r, 64'd0);
        @(negedge clk);

        // randomized ops with occasional flush, reset and stray starts
        for (int it = 0; it < 150; it++) begin
            s = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: begin a = MIN64; b = ONES64; end
                2: b = 64'($urandom_range(1, 20));
                3: a = 64'($urandom_range(0, 1000));
                4: b = b >> $urandom_range(1, 63);
                default: ;
            endcase
            issue(s, a, b);
            act = $urandom_range(0, 9);
            if (act == 0) begin
                repeat ($urandom_range(0, 66)) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end else if (act == 1) begin
                repeat ($urandom_range(0, 66)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (act == 2) begin
                repeat ($urandom_range(0, 60)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            drain();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // 32-bit instance
        start32 = 1'b1; sop32 = 1'b0; dvd32 = 32'hFFFF_FFFF; dvs32 = 32'd1;
        @(negedge clk);
        start32 = 1'b0; dvd32 = 32'd7; dvs32 = 32'd7;
        cyc = 1;
        while (!done32 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("x32_latency", 64'(cyc), 64'd34);
        chk("x32_q", 64'(q32), 64'hFFFF_FFFF);
        chk("x32_r", 64'(r32), 64'd0);
        @(negedge clk);
        start32 = 1'b1; dvd32 = 32'hFFFF_FFFF; dvs32 = 32'd1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        rst32 = 1'b1;
        #1;
        chk("x32_rst_q", 64'(q32), 64'd0);
        chk("x32_rst_r", 64'(r32), 64'd0);
        chk("x32_rst_busy", 64'(busy32), 64'd0);
        chk("x32_rst_done", 64'(done32), 64'd0);
        @(negedge clk);
        rst32 = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (done32) seen++;
        end
        chk("x32_rst_no_done", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
